pingpong_write_ctrl: RTL and testbench
======================================

PINGPONG_WRITE_CTRL -- requirements
Module: pingpong_write_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the number of words per bank (legal range 2..65536).
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the write-data width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the producer offers a word.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: the producer word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the controller accepts a word this cycle.
REQ-008 The block SHALL have port bank_release, input, 2 bits: one-cycle pulse per bank; the consumer has finished reading bank i.
REQ-009 The block SHALL have port we, output, 1 bit: write enable to the 1-to-2 demux.
REQ-010 The block SHALL have port data, output, 16 bits: write data to the demux.
REQ-011 The block SHALL have port addr, output, 16 bits: write address to the demux.
REQ-012 The block SHALL have port select, output, 1 bit: demux select; 0 = bank 0, 1 = bank 1.
REQ-013 The block SHALL have port bank_full, output, 2 bits: bank i holds a complete frame awaiting release.
REQ-014 The block SHALL have port bank_done, output, 2 bits: one-cycle pulse when bank i becomes full.

Function
REQ-015 A transfer SHALL occur when in_valid and in_ready are both 1 in the same cycle.
REQ-016 in_ready SHALL be 1 exactly when the FSM is in FILL and bank_full[wr_sel] = 0 (decoded from registers only).
REQ-017 On each transfer, the block SHALL register we=1, data=in_data, addr=wr_addr and select=wr_sel, visible on the next cycle (latency 1); otherwise we SHALL be 0 and data/addr/select SHALL hold.
REQ-018 wr_addr SHALL increment by 1 per transfer; on a transfer at wr_addr = DEPTH-1, it SHALL return to 0, bank_full[wr_sel] and bank_done[wr_sel] SHALL be set, and wr_sel SHALL toggle.
REQ-019 The FSM SHALL have two states, FILL and STALL.
REQ-020 FILL -> STALL SHALL occur when a bank completes and the other bank is still full with no release of it in that cycle.
REQ-021 STALL -> FILL SHALL occur in the cycle after bank_release[wr_sel] is pulsed.
REQ-022 bank_release[i] SHALL clear bank_full[i] on the next edge; a release of a bank that is not full SHALL be ignored.
REQ-023 If bank i completes and bank_release[i] is pulsed in the same cycle, the set SHALL win.
REQ-024 When the release of the other bank coincides with the completion of the current bank, the FSM SHALL stay in FILL with no stall cycle.
REQ-025 Both bits of bank_release SHALL be allowed in the same cycle, and each SHALL be handled independently.
REQ-026 When DATA_W differs from 16, data SHALL be zero-extended or truncated to 16 bits.

Reset
REQ-027 While rst=1, the block SHALL drive we=0, data=0, addr=0, select=0, bank_full=00, bank_done=00, in_ready=0, wr_addr=0, wr_sel=0 and state FILL.
REQ-028 A reset mid-frame SHALL discard the partial frame and all full flags, and writing SHALL restart at bank 0, address 0.
REQ-029 in_ready SHALL be 1 in the first cycle after rst is deasserted.

Structure
REQ-030 The FSM state encoding (FILL, STALL) SHALL be a shared typedef in the cnn_buf_pkg package, alongside the constant BANK_ADDR_W = 16.
REQ-031 The FSM SHALL be a single flat module with no sub-modules, and it SHALL drive the existing multi_one_to_two_demux instantiated at the parent level.

Verification
REQ-032 With DEPTH=4, stream 4 words 0xA0..0xA3 -> we pulses with addr 0..3 and select=0; bank_done[0] pulses one cycle after the 4th transfer; bank_full=01.
REQ-033 With DEPTH=4, stream 8 words with no release -> bank_full=11; in_ready=0 and state STALL; the 9th word is held by the producer.
REQ-034 From the stall in REQ-033, pulse bank_release[0] -> in_ready=1 one cycle later; the next write is addr 0, select=0.
REQ-035 Pulse bank_release[1] at the same edge as the last write of bank 0, with bank 1 full -> no stall; the next cycle writes addr 0, select=1.
REQ-036 Assert rst after 2 writes into bank 1 -> all outputs return to 0; the first post-reset write is addr 0, select=0.
REQ-037 Drive a random in_valid duty cycle over 1000 words, with the consumer releasing at random -> data order is preserved per bank, addresses never skip, and no write ever targets a bank that is full.

Source files
------------

// File: rtl/cnn_buf_pkg.sv
// ============================================================================
// Module      : cnn_buf_pkg
// Description : Shared types and constants for the CNN ping-pong buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_buf_pkg;

    localparam int BANK_ADDR_W = 16;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        STALL = 1'b1
    } wr_state_t;

endpackage : cnn_buf_pkg

`default_nettype wire

// File: rtl/pingpong_write_ctrl.sv
// ============================================================================
// Module      : pingpong_write_ctrl
// Description : Write-side controller steering a producer stream into two
//               alternating banks through an external 1-to-2 demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_write_ctrl
    import cnn_buf_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [1:0]        bank_release,
    output logic              we,
    output logic [15:0]       data,
    output logic [15:0]       addr,
    output logic              select,
    output logic [1:0]        bank_full,
    output logic [1:0]        bank_done
);

    localparam logic [BANK_ADDR_W-1:0] c_last_addr = BANK_ADDR_W'(DEPTH - 1);

    wr_state_t              r_state;
    wr_state_t              w_state_nxt;
    logic                   r_run;
    logic [BANK_ADDR_W-1:0] r_wr_addr;
    logic                   r_wr_sel;
    logic [1:0]             r_bank_full;
    logic [1:0]             r_bank_done;
    logic                   r_we;
    logic [15:0]            r_data;
    logic [15:0]            r_addr;
    logic                   r_sel;

    logic                   w_ready;
    logic                   w_xfer;
    logic                   w_complete;
    logic                   w_other;
    logic [1:0]             w_done_nxt;
    logic [1:0]             w_full_nxt;
    logic [15:0]            w_data_ext;

    generate
        if (DATA_W >= 16) begin : g_data_trunc
            assign w_data_ext = in_data[15:0];
        end else begin : g_data_zext
            assign w_data_ext = {{(16 - DATA_W){1'b0}}, in_data};
        end
    endgenerate

    // r_run keeps in_ready low through reset while staying a pure register decode
    assign w_ready    = r_run && (r_state == FILL) && !r_bank_full[r_wr_sel];
    assign w_xfer     = in_valid && w_ready;
    assign w_complete = w_xfer && (r_wr_addr == c_last_addr);
    assign w_other    = ~r_wr_sel;

    always_comb begin
        w_done_nxt  = 2'b00;
        w_state_nxt = r_state;
        if (w_complete) begin
            w_done_nxt[r_wr_sel] = 1'b1;
        end
        // a completion in the same cycle as a release of that bank keeps it full
        w_full_nxt = (r_bank_full & ~bank_release) | w_done_nxt;
        case (r_state)
            FILL: begin
                if (w_complete && r_bank_full[w_other] && !bank_release[w_other]) begin
                    w_state_nxt = STALL;
                end
            end
            STALL: begin
                if (bank_release[r_wr_sel]) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_run       <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_sel    <= 1'b0;
            r_bank_full <= 2'b00;
            r_bank_done <= 2'b00;
            r_we        <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
            r_sel       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= 1'b1;
            r_bank_full <= w_full_nxt;
            r_bank_done <= w_done_nxt;
            r_we        <= w_xfer;
            if (w_xfer) begin
                r_data <= w_data_ext;
                r_addr <= r_wr_addr;
                r_sel  <= r_wr_sel;
                if (w_complete) begin
                    r_wr_addr <= '0;
                    r_wr_sel  <= ~r_wr_sel;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign we        = r_we;
    assign data      = r_data;
    assign addr      = r_addr;
    assign select    = r_sel;
    assign bank_full = r_bank_full;
    assign bank_done = r_bank_done;

endmodule : pingpong_write_ctrl

`default_nettype wire

// File: tb/tb_pingpong_write_ctrl.sv
// ============================================================================
// Module      : tb_pingpong_write_ctrl
// Description : Scoreboard bench for pingpong_write_ctrl with DEPTH = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pingpong_write_ctrl;

    localparam int TB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [1:0]  bank_release = 2'b00;
    logic        we;
    logic [15:0] data;
    logic [15:0] addr;
    logic        select;
    logic [1:0]  bank_full;
    logic [1:0]  bank_done;

    pingpong_write_ctrl #(.DEPTH(TB_DEPTH), .DATA_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .bank_release (bank_release),
        .we           (we),
        .data         (data),
        .addr         (addr),
        .select       (select),
        .bank_full    (bank_full),
        .bank_done    (bank_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // expected write: {addr[15:0], select, data[15:0]}
    logic [32:0] exp_q[$];

    // reference model of the controller, advanced on each rising edge
    logic        m_run   = 1'b0;
    logic        m_stall = 1'b0;
    logic [15:0] m_addr  = '0;
    logic        m_sel   = 1'b0;
    logic [1:0]  m_full  = 2'b00;
    logic [1:0]  m_done  = 2'b00;
    logic        m_we    = 1'b0;

    function automatic logic m_ready();
        return m_run && !m_stall && !m_full[m_sel];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        automatic logic       xfer;
        automatic logic       last;
        automatic logic [1:0] done_n;
        automatic logic       stall_n;
        if (rst) begin
            m_run   <= 1'b0;
            m_stall <= 1'b0;
            m_addr  <= '0;
            m_sel   <= 1'b0;
            m_full  <= 2'b00;
            m_done  <= 2'b00;
            m_we    <= 1'b0;
        end else begin
            xfer    = in_valid && m_ready();
            last    = (m_addr == 16'(TB_DEPTH - 1));
            done_n  = 2'b00;
            stall_n = m_stall;
            if (xfer && last) done_n[m_sel] = 1'b1;
            if (!m_stall) begin
                if (xfer && last && m_full[!m_sel] && !bank_release[!m_sel]) stall_n = 1'b1;
            end else if (bank_release[m_sel]) begin
                stall_n = 1'b0;
            end
            if (xfer) begin
                exp_q.push_back({m_addr, m_sel, in_data});
                m_addr <= last ? 16'd0 : m_addr + 16'd1;
                if (last) m_sel <= !m_sel;
            end
            m_run   <= 1'b1;
            m_stall <= stall_n;
            m_full  <= (m_full & ~bank_release) | done_n;
            m_done  <= done_n;
            m_we    <= xfer;
        end
    end

    always @(negedge clk) begin : monitor
        automatic logic [32:0] e;
        if (mon_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            chk("we", 32'(we), 32'(m_we));
            chk("bank_full", 32'(bank_full), 32'(m_full));
            chk("bank_done", 32'(bank_done), 32'(m_done));
            if (we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h sel %0d data 0x%0h, expected none", addr, select, data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(addr), 32'(e[32:17]));
                    chk("wr_select", 32'(select), 32'(e[16]));
                    chk("wr_data", 32'(data), 32'(e[15:0]));
                end
            end
        end
    end

    // offer one word; returns at the falling edge after it was accepted
    task automatic send(input logic [15:0] d);
        bit ok;
        bit r;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 64; i++) begin
            r = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept for 0x%0h, expected accept within 64 cycles", d);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_select"}, 32'(select), 32'd0);
        chk({tag, "_full"}, 32'(bank_full), 32'd0);
        chk({tag, "_done"}, 32'(bank_done), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int  n;
        int  cyc;
        bit  r;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        mon_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // one full frame into bank 0
        for (int i = 0; i < 4; i++) send(16'hA0 + 16'(i));
        in_valid = 1'b0;
        chk("done0_pulse", 32'(bank_done), 32'b01);
        @(negedge clk);
        chk("full_after_bank0", 32'(bank_full), 32'b01);
        chk("done_cleared", 32'(bank_done), 32'b00);

        // second frame fills bank 1 with bank 0 still held -> stall
        for (int i = 0; i < 4; i++) send(16'hB0 + 16'(i));
        chk("full_both", 32'(bank_full), 32'b11);
        chk("stall_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'hC0;
        repeat (3) @(negedge clk);
        chk("ninth_held", 32'(in_ready), 32'd0);

        // releasing bank 0 resumes writing at bank 0 address 0
        bank_release = 2'b01;
        @(negedge clk);
        bank_release = 2'b00;
        chk("ready_after_release", 32'(in_ready), 32'd1);
        chk("full_after_release", 32'(bank_full), 32'b10);
        send(16'hC0);
        send(16'hC1);
        send(16'hC2);

        // bank 1 release coincides with completion of bank 0 -> no stall
        in_data      = 16'hC3;
        bank_release = 2'b10;
        r = in_ready;
        @(posedge clk);
        @(negedge clk);
        bank_release = 2'b00;
        chk("c3_accepted", 32'(r), 32'd1);
        chk("no_stall_ready", 32'(in_ready), 32'd1);
        chk("full_swap", 32'(bank_full), 32'b01);
        send(16'hD0);
        send(16'hD1);
        in_valid = 1'b0;
        @(negedge clk);

        // mid-frame reset discards everything
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", 32'(in_ready), 32'd1);
        bank_release = 2'b11;
        @(negedge clk);
        bank_release = 2'b00;
        chk("release_empty_ignored", 32'(bank_full), 32'b00);
        send(16'hE0);
        in_valid = 1'b0;
        @(negedge clk);

        // random producer duty cycle and random consumer releases
        n   = 0;
        cyc = 0;
        while (n < 1000 && cyc < 30000) begin
            in_valid     = ($urandom_range(0, 9) < 6);
            in_data      = 16'h1000 + 16'(n);
            bank_release = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            r = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r && in_valid) n++;
            cyc++;
        end
        in_valid     = 1'b0;
        bank_release = 2'b00;
        chk("random_words", 32'(n), 32'd1000);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pingpong_write_ctrl

`default_nettype wire
